// File: rtl/uart_prog_loader.sv
// UART program loader: receives an 0xA5-framed, checksummed image over 8N1 and writes it into RAM.
// Optional inter-byte timeout abort is compiled in when PROG_LOADER_TIMEOUT_EN is defined.
module uart_prog_loader #(
    parameter int          CLKS_PER_BIT = 434,
    parameter logic [15:0] BASE_ADDR    = 16'h0000,
    parameter int          TIMEOUT_CYC  = 5000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    output logic        we,
    output logic [15:0] addr,
    output logic [7:0]  wdata,
    output logic        busy,
    output logic        run,
    output logic        err
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [7:0]    SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {F_IDLE, F_LENL, F_LENH, F_DATA, F_CSUM} fr_state_t;

    logic            rxd_s1, rxd_s2, rxd_s3;
    rx_state_t       rx_state, rx_state_nxt;
    logic [CW-1:0]   rx_cnt, rx_cnt_nxt;
    logic [2:0]      rx_bit, rx_bit_nxt;
    logic [7:0]      rx_shift, rx_shift_nxt;
    logic            rx_vld_p0, rx_ferr_p0;

    fr_state_t       fr_state, fr_state_nxt;
    logic [15:0]     len, len_nxt;
    logic [15:0]     idx, idx_nxt;
    logic [7:0]      sum, sum_nxt;
    logic            we_nxt, busy_nxt, run_nxt, err_nxt;
    logic [15:0]     addr_nxt;
    logic [7:0]      wdata_nxt;
    logic            to_hit;

    // Input synchronizer; the third flop gives the previous level for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_s1 <= 1'b1;
            rxd_s2 <= 1'b1;
            rxd_s3 <= 1'b1;
        end else begin
            rxd_s1 <= rxd;
            rxd_s2 <= rxd_s1;
            rxd_s3 <= rxd_s2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
        end else begin
            rx_state <= rx_state_nxt;
            rx_cnt   <= rx_cnt_nxt;
            rx_bit   <= rx_bit_nxt;
        end
    end

    always_ff @(posedge clk) begin
        rx_shift <= rx_shift_nxt;
    end

    // Only a falling edge arms the receiver, so a line held low after a framing error cannot retrigger
    always_comb begin
        rx_state_nxt = rx_state;
        rx_cnt_nxt   = rx_cnt + CW'(1);
        rx_bit_nxt   = rx_bit;
        rx_shift_nxt = rx_shift;
        rx_vld_p0    = 1'b0;
        rx_ferr_p0   = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_nxt = '0;
                rx_bit_nxt = '0;
                if (rxd_s3 && !rxd_s2) rx_state_nxt = RX_START;
            end
            RX_START: begin
                if (rx_cnt == HALF_M1) begin
                    rx_cnt_nxt   = '0;
                    rx_state_nxt = rxd_s2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt == FULL_M1) begin
                    rx_cnt_nxt   = '0;
                    rx_shift_nxt = {rxd_s2, rx_shift[7:1]};
                    rx_bit_nxt   = rx_bit + 3'd1;
                    if (rx_bit == 3'd7) rx_state_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_cnt == FULL_M1) begin
                    rx_cnt_nxt   = '0;
                    rx_state_nxt = RX_IDLE;
                    rx_vld_p0    = rxd_s2;
                    rx_ferr_p0   = !rxd_s2;
                end
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

`ifdef PROG_LOADER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge clk) begin
        if (rst || fr_state == F_IDLE || rx_vld_p0) to_cnt <= '0;
        else                                         to_cnt <= to_cnt + TO_W'(1);
    end

    assign to_hit = (fr_state != F_IDLE) && !rx_vld_p0 && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
    // No timeout in this build: constant 0 for any legal TIMEOUT_CYC
    assign to_hit = (TIMEOUT_CYC < 0);
`endif

    // ---- stage p1: frame decode, registered RAM write / run / status outputs ----
    always_ff @(posedge clk) begin
        if (rst) begin
            fr_state <= F_IDLE;
            we       <= 1'b0;
            addr     <= '0;
            wdata    <= '0;
            busy     <= 1'b0;
            run      <= 1'b0;
            err      <= 1'b0;
        end else begin
            fr_state <= fr_state_nxt;
            we       <= we_nxt;
            addr     <= addr_nxt;
            wdata    <= wdata_nxt;
            busy     <= busy_nxt;
            run      <= run_nxt;
            err      <= err_nxt;
        end
    end

    always_ff @(posedge clk) begin
        len <= len_nxt;
        idx <= idx_nxt;
        sum <= sum_nxt;
    end

    always_comb begin
        fr_state_nxt = fr_state;
        len_nxt      = len;
        idx_nxt      = idx;
        sum_nxt      = sum;
        we_nxt       = 1'b0;
        run_nxt      = 1'b0;
        addr_nxt     = addr;
        wdata_nxt    = wdata;
        busy_nxt     = busy;
        err_nxt      = err;
        case (fr_state)
            F_IDLE: begin
                if (rx_vld_p0 && rx_shift == SYNC_BYTE) begin
                    fr_state_nxt = F_LENL;
                    busy_nxt     = 1'b1;
                    err_nxt      = 1'b0;
                    idx_nxt      = '0;
                    sum_nxt      = '0;
                end
            end
            F_LENL: begin
                if (rx_vld_p0) begin
                    len_nxt[7:0] = rx_shift;
                    fr_state_nxt = F_LENH;
                end
            end
            F_LENH: begin
                if (rx_vld_p0) begin
                    len_nxt[15:8] = rx_shift;
                    fr_state_nxt  = ({rx_shift, len[7:0]} == 16'd0) ? F_CSUM : F_DATA;
                end
            end
            F_DATA: begin
                if (rx_vld_p0) begin
                    we_nxt    = 1'b1;
                    addr_nxt  = BASE_ADDR + idx;
                    wdata_nxt = rx_shift;
                    sum_nxt   = sum + rx_shift;
                    idx_nxt   = idx + 16'd1;
                    if (idx == len - 16'd1) fr_state_nxt = F_CSUM;
                end
            end
            F_CSUM: begin
                if (rx_vld_p0) begin
                    fr_state_nxt = F_IDLE;
                    busy_nxt     = 1'b0;
                    if (rx_shift == sum) run_nxt = 1'b1;
                    else                 err_nxt = 1'b1;
                end
            end
            default: fr_state_nxt = F_IDLE;
        endcase

        // A bad stop bit or a stall mid-frame abandons the frame; bytes already written remain
        if (fr_state != F_IDLE && (rx_ferr_p0 || to_hit)) begin
            fr_state_nxt = F_IDLE;
            busy_nxt     = 1'b0;
            err_nxt      = 1'b1;
            we_nxt       = 1'b0;
            run_nxt      = 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: two instances (BASE_ADDR 0 and FFFE) on one RX line, frame-level model.
module tb_uart_prog_loader;

    localparam int CPB = 16;
    localparam int TO  = 400;

    logic        clk = 1'b0;
    logic        rst;
    logic        rxd;
    logic        we0, we1, busy0, busy1, run0, run1, err0, err1;
    logic [15:0] addr0, addr1;
    logic [7:0]  wdata0, wdata1;

    always #5 clk = ~clk;

    uart_prog_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(16'h0000), .TIMEOUT_CYC(TO)) dut0 (
        .clk(clk), .rst(rst), .rxd(rxd), .we(we0), .addr(addr0), .wdata(wdata0),
        .busy(busy0), .run(run0), .err(err0));

    uart_prog_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(16'hFFFE), .TIMEOUT_CYC(TO)) dut1 (
        .clk(clk), .rst(rst), .rxd(rxd), .we(we1), .addr(addr1), .wdata(wdata1),
        .busy(busy1), .run(run1), .err(err1));

    typedef struct packed {
        logic [7:0]  d;
        logic [15:0] idx;
    } wr_t;

    int          total = 0;
    int          bad   = 0;
    int          run_cnt = 0;
    wr_t         exp_q[$];
    logic [15:0] log_a0[$], log_a1[$];
    logic [7:0]  log_d[$];
    bit          m_err = 1'b0;
    bit          m_busy = 1'b0;
    wr_t         cmp_e;
    logic [15:0] cmp_a1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Every write and run pulse is checked against the model as it happens
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (we0 || we1) begin
                check("we_pair", we1, we0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL we_unexpected: got write addr=%0h data=%0h want none", addr0, wdata0);
                end else begin
                    cmp_e  = exp_q.pop_front();
                    cmp_a1 = 16'hFFFE + cmp_e.idx;
                    check("addr0", addr0, cmp_e.idx);
                    check("addr1", addr1, cmp_a1);
                    check("wdata0", wdata0, cmp_e.d);
                    check("wdata1", wdata1, cmp_e.d);
                end
                log_a0.push_back(addr0);
                log_a1.push_back(addr1);
                log_d.push_back(wdata0);
            end
            if (run0 || run1) begin
                check("run_pair", run1, run0);
                check("run_we_excl", we0, 0);
                check("run_after_writes", exp_q.size(), 0);
                run_cnt++;
            end
        end
    end

    // Frame-level model: find the sync byte, read LEN, queue the data writes, judge the checksum.
    // badi = index of a byte sent with a bad stop bit (-1 for none); nothing after it is sent.
    task automatic model(input logic [7:0] b[$], input int badi, output bit run_e);
        int         n, s, len;
        logic [7:0] sm;
        wr_t        w;
        run_e = 1'b0;
        n = (badi >= 0) ? badi : b.size();
        s = -1;
        for (int i = 0; i < n; i++) begin
            if (b[i] == 8'hA5) begin
                s = i;
                break;
            end
        end
        if (s < 0) return;
        m_err  = 1'b0;
        m_busy = 1'b1;
        if (s + 2 >= n) begin
            if (badi >= 0) begin
                m_err  = 1'b1;
                m_busy = 1'b0;
            end
            return;
        end
        len = {b[s+2], b[s+1]};
        sm  = 8'h00;
        for (int k = 0; k < len && s + 3 + k < n; k++) begin
            w.d   = b[s+3+k];
            w.idx = k[15:0];
            exp_q.push_back(w);
            sm = sm + b[s+3+k];
        end
        if (s + 3 + len < n) begin
            m_busy = 1'b0;
            if (b[s+3+len] == sm) run_e = 1'b1;
            else                  m_err = 1'b1;
        end else if (badi >= 0) begin
            m_err  = 1'b1;
            m_busy = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stop_ok;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic glitch();
        rxd = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        rxd = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic run_frame(input string name, input logic [7:0] b[$], input int badi,
                             input int glitch_at, input int gap_max);
        int rc0;
        bit run_e;
        rc0 = run_cnt;
        model(b, badi, run_e);
        for (int i = 0; i < b.size(); i++) begin
            if (badi >= 0 && i > badi) break;
            if (i == glitch_at) glitch();
            send_byte(b[i], i != badi);
            idle((i == badi) ? 3 * CPB : $urandom_range(gap_max, 1));
        end
        idle(2 * CPB);
        check({name, "_run"}, run_cnt - rc0, run_e);
        check({name, "_err0"}, err0, m_err);
        check({name, "_err1"}, err1, m_err);
        check({name, "_busy"}, busy0, m_busy);
        check({name, "_wrdone"}, exp_q.size(), 0);
    endtask

    initial begin
        logic [7:0] fr[$];
        bit         run_e;
        int         nstray, len, badi, gl;
        logic [7:0] sm, v;

        rst = 1'b1;
        rxd = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_we", we0, 0);
        check("rst_addr0", addr0, 0);
        check("rst_addr1", addr1, 0);
        check("rst_wdata", wdata0, 0);
        check("rst_busy", busy0, 0);
        check("rst_run", run0, 0);
        check("rst_err", err0, 0);

        // Pin the model on a hand-worked bad-checksum frame
        fr = '{8'hA5, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h67};
        model(fr, -1, run_e);
        check("model_run", run_e, 0);
        check("model_err", m_err, 1);
        check("model_nwr", exp_q.size(), 3);
        check("model_d2", exp_q[2].d, 8'h33);
        exp_q.delete();
        m_err  = 1'b0;
        m_busy = 1'b0;

        // Basic frame with literal address/data expectations on both instances
        log_a0.delete(); log_a1.delete(); log_d.delete();
        fr = '{8'hA5, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h66};
        run_frame("basic", fr, -1, -1, 2 * CPB);
        check("basic_nwr", log_d.size(), 3);
        check("basic_a0_0", log_a0[0], 16'h0000);
        check("basic_a0_2", log_a0[2], 16'h0002);
        check("basic_a1_0", log_a1[0], 16'hFFFE);
        check("basic_a1_1", log_a1[1], 16'hFFFF);
        check("basic_a1_2", log_a1[2], 16'h0000);
        check("basic_d1", log_d[1], 8'h22);

        fr = '{8'hA5, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h67};
        run_frame("badsum", fr, -1, -1, 2 * CPB);
        check("badsum_err_lit", err0, 1);

        fr = '{8'hA5, 8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h06};
        run_frame("after_err", fr, -1, -1, 2 * CPB);
        check("after_err_lit", err0, 0);

        fr = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00};
        run_frame("len0", fr, -1, -1, 2 * CPB);

        fr = '{8'hA5, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h66};
        run_frame("ferr", fr, 4, -1, 2 * CPB);
        check("ferr_err_lit", err0, 1);

        fr = '{8'hA5, 8'h02, 8'h00, 8'h40, 8'h41, 8'h81};
        run_frame("glitch", fr, -1, 3, 2 * CPB);

        // Reset in the middle of the data phase
        fr = '{8'hA5, 8'h05, 8'h00, 8'h10, 8'h20};
        model(fr, -1, run_e);
        foreach (fr[i]) begin
            send_byte(fr[i], 1'b1);
            idle(CPB);
        end
        idle(2 * CPB);
        check("midrst_busy_pre", busy0, 1);
        check("midrst_wrdone", exp_q.size(), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_we", we0, 0);
        check("midrst_addr1", addr1, 0);
        check("midrst_wdata", wdata0, 0);
        check("midrst_busy", busy0, 0);
        check("midrst_run", run0, 0);
        check("midrst_err", err0, 0);
        m_err  = 1'b0;
        m_busy = 1'b0;
        fr = '{8'hA5, 8'h01, 8'h00, 8'h5A, 8'h5A};
        run_frame("postrst", fr, -1, -1, 2 * CPB);

`ifdef PROG_LOADER_TIMEOUT_EN
        fr = '{8'hA5, 8'h05, 8'h00};
        model(fr, -1, run_e);
        foreach (fr[i]) begin
            send_byte(fr[i], 1'b1);
            idle(CPB);
        end
        check("stall_busy_pre", busy0, 1);
        idle(TO + 50);
        check("stall_err", err0, 1);
        check("stall_busy", busy0, 0);
        m_err  = 1'b1;
        m_busy = 1'b0;
`endif

        // Randomized frames: stray bytes, checksum errors, bad stop bits, start glitches
        for (int t = 0; t < 20; t++) begin
            fr.delete();
            nstray = $urandom_range(2, 0);
            for (int i = 0; i < nstray; i++) begin
                v = 8'($urandom_range(255, 0));
                if (v == 8'hA5) v = 8'h5A;
                fr.push_back(v);
            end
            len = $urandom_range(5, 0);
            fr.push_back(8'hA5);
            fr.push_back(len[7:0]);
            fr.push_back(8'h00);
            sm = 8'h00;
            for (int i = 0; i < len; i++) begin
                v = 8'($urandom_range(255, 0));
                fr.push_back(v);
                sm = sm + v;
            end
            if ($urandom_range(3, 0) == 0) sm = sm ^ 8'(1 + $urandom_range(254, 0));
            fr.push_back(sm);
            badi = ($urandom_range(4, 0) == 0) ? $urandom_range(fr.size() - 1, nstray + 1) : -1;
            gl   = ($urandom_range(3, 0) == 0) ? $urandom_range(fr.size() - 1, 0) : -1;
            run_frame("rand", fr, badi, gl, 3 * CPB);
        end

        check("final_wrdone", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
